scene_painter: RTL and testbench

- Parametrised frame compositor. Fills the frame with a background palette, then copies up to MAX_ELEMENTS sprite rectangles into the frame in index order, so a higher index overdraws a lower one.
- Element descriptors sit in an internal register table. Software or game logic writes the table at run time, so no hard-wired scene is needed.
- Emits one pixel write per beat on a valid/ready stream to the framebuffer writer. Reads sprite pixels from an external synchronous sprite ROM.

---
 rtl/scene_painter.sv | 241 ++++++++++++++++++++++++
 tb/tb_scene_painter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_painter.sv
// scene_painter: frame compositor. Paints the whole frame with BG_PALETTE,
// then copies up to MAX_ELEMENTS sprite rectangles from an external sprite
// ROM into the frame in descriptor-index order, so later elements overdraw
// earlier ones. Emits one pixel beat per cycle on a valid/ready stream.
//
// Optional build macro: TRANSPARENT_EN
//   When defined, a sprite pixel with ROM palette 0 is dropped at the output
//   register and the background already written there shows through.
//
// Ports:
//   clk_33m, rst            clock, synchronous active-high reset
//   start, element_count    begin a frame / descriptors to paint (sampled at start)
//   busy, done              frame in progress / one-cycle completion pulse
//   desc_*                  descriptor table write port
//   sprite_rd, sprite_addr_x/y, sprite_palette
//                           sprite ROM (1-cycle read latency, data held when idle)
//   write_valid/ready, write_x/y, write_palette
//                           pixel stream to the framebuffer writer
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_BG     | rastering the whole frame with BG_PALETTE
// S_LOAD   | latching descriptor[idx], skipping disabled or empty ones
// S_SPRITE | rastering the current rectangle, clipping off-frame pixels
// S_NEXT   | advancing idx, or finishing after the last descriptor
// S_DONE   | one-cycle done pulse
module scene_painter #(
  parameter int         COOR_WIDTH   = 12,
  parameter int         MAX_ELEMENTS = 32,
  parameter int         INDEX_WIDTH  = 5,
  parameter int         FRAME_WIDTH  = 1280,
  parameter int         FRAME_HEIGHT = 250,
  parameter logic [1:0] BG_PALETTE   = 2'd0
) (
  input  logic                  clk_33m,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INDEX_WIDTH:0]  element_count,
  output logic                  busy,
  output logic                  done,
  input  logic                  desc_we,
  input  logic [INDEX_WIDTH-1:0] desc_addr,
  input  logic                  desc_en,
  input  logic [COOR_WIDTH-1:0] desc_sprite_x,
  input  logic [COOR_WIDTH-1:0] desc_sprite_y,
  input  logic [COOR_WIDTH-1:0] desc_frame_x,
  input  logic [COOR_WIDTH-1:0] desc_frame_y,
  input  logic [COOR_WIDTH-1:0] desc_width,
  input  logic [COOR_WIDTH-1:0] desc_height,
  output logic                  sprite_rd,
  output logic [COOR_WIDTH-1:0] sprite_addr_x,
  output logic [COOR_WIDTH-1:0] sprite_addr_y,
  input  logic [1:0]            sprite_palette,
  output logic                  write_valid,
  input  logic                  write_ready,
  output logic [COOR_WIDTH-1:0] write_x,
  output logic [COOR_WIDTH-1:0] write_y,
  output logic [1:0]            write_palette
);

  localparam int CW = COOR_WIDTH;
  localparam logic [CW:0]          FW      = (CW+1)'(FRAME_WIDTH);
  localparam logic [CW:0]          FH      = (CW+1)'(FRAME_HEIGHT);
  localparam logic [CW-1:0]        FW_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [CW-1:0]        FH_LAST = CW'(FRAME_HEIGHT - 1);
  localparam logic [INDEX_WIDTH:0] MAX_CNT = (INDEX_WIDTH+1)'(MAX_ELEMENTS);

  typedef enum logic [2:0] {S_IDLE, S_BG, S_LOAD, S_SPRITE, S_NEXT, S_DONE} state_t;
  state_t state, state_nx;

  // descriptor table
  logic [MAX_ELEMENTS-1:0] tbl_en;
  logic [CW-1:0] tbl_sx [MAX_ELEMENTS];
  logic [CW-1:0] tbl_sy [MAX_ELEMENTS];
  logic [CW-1:0] tbl_fx [MAX_ELEMENTS];
  logic [CW-1:0] tbl_fy [MAX_ELEMENTS];
  logic [CW-1:0] tbl_w  [MAX_ELEMENTS];
  logic [CW-1:0] tbl_h  [MAX_ELEMENTS];

  always_ff @(posedge clk_33m) begin
    if (rst) tbl_en <= '0;
    else if (desc_we) tbl_en[desc_addr] <= desc_en;
  end

  always_ff @(posedge clk_33m) begin
    if (desc_we) begin
      tbl_sx[desc_addr] <= desc_sprite_x;
      tbl_sy[desc_addr] <= desc_sprite_y;
      tbl_fx[desc_addr] <= desc_frame_x;
      tbl_fy[desc_addr] <= desc_frame_y;
      tbl_w[desc_addr]  <= desc_width;
      tbl_h[desc_addr]  <= desc_height;
    end
  end

  logic [INDEX_WIDTH:0]   idx, cnt;
  logic [INDEX_WIDTH-1:0] ld_idx;
  logic                   ld_skip;
  logic [CW-1:0] cur_sx, cur_sy, cur_fx, cur_fy, cur_w, cur_h;

  assign ld_idx  = idx[INDEX_WIDTH-1:0];
  assign ld_skip = !tbl_en[ld_idx] || (tbl_w[ld_idx] == '0) || (tbl_h[ld_idx] == '0);

  // generate stage: gx/gy are frame x/y in S_BG and col/row in S_SPRITE
  logic [CW-1:0] gx, gy;
  logic          gen_done;
  logic [CW:0]   fx, fy;
  logic          in_bg, in_spr, clip_x, clip_y;
  logic          gen_live, gen_clip, gen_fire, gen_step, last_col, last_row;
  logic          advance, out_pend, out_spr, drop;

  assign in_bg    = (state == S_BG);
  assign in_spr   = (state == S_SPRITE);
  assign fx       = {1'b0, cur_fx} + {1'b0, gx};
  assign fy       = {1'b0, cur_fy} + {1'b0, gy};
  assign clip_x   = (fx >= FW);
  assign clip_y   = (fy >= FH);
  assign advance  = !write_valid || write_ready;
  assign gen_live = (in_bg || in_spr) && !gen_done;
  assign gen_clip = in_spr && (clip_x || clip_y);
  assign gen_fire = gen_live && !gen_clip && advance;
  // clipped pixels never occupy the output register, so they step even in a stall
  assign gen_step = gen_live && (gen_clip || advance);
  // once a column leaves the frame the rest of that row is off-frame too
  assign last_col = in_bg ? (gx == FW_LAST) : ((gx == cur_w - 1'b1) || clip_x);
  assign last_row = in_bg ? (gy == FH_LAST) : (gy == cur_h - 1'b1);

  assign sprite_rd     = gen_fire && in_spr;
  assign sprite_addr_x = cur_sx + gx;
  assign sprite_addr_y = cur_sy + gy;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      gx       <= '0;
      gy       <= '0;
      gen_done <= 1'b0;
    end else if (state == S_IDLE || state == S_LOAD) begin
      gx       <= '0;
      gy       <= '0;
      gen_done <= 1'b0;
    end else if (gen_step) begin
      // rows only increase, so a clipped row means everything after it is clipped
      if (in_spr && clip_y) gen_done <= 1'b1;
      else if (last_col) begin
        gx <= '0;
        if (last_row) gen_done <= 1'b1;
        else          gy <= gy + 1'b1;
      end else gx <= gx + 1'b1;
    end
  end

  // output register; sprite palette arrives from the ROM while the beat is held
  always_ff @(posedge clk_33m) begin
    if (rst) begin
      out_pend <= 1'b0;
      out_spr  <= 1'b0;
      write_x  <= '0;
      write_y  <= '0;
    end else if (advance) begin
      out_pend <= gen_fire;
      if (gen_fire) begin
        write_x <= in_bg ? gx : fx[CW-1:0];
        write_y <= in_bg ? gy : fy[CW-1:0];
        out_spr <= in_spr;
      end
    end
  end

`ifdef TRANSPARENT_EN
  assign drop = out_spr && (sprite_palette == 2'd0);
`else
  assign drop = 1'b0;
`endif

  assign write_valid   = out_pend && !drop;
  assign write_palette = write_valid ? (out_spr ? sprite_palette : BG_PALETTE) : 2'd0;

  always_ff @(posedge clk_33m) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      cur_sx <= '0;
      cur_sy <= '0;
      cur_fx <= '0;
      cur_fy <= '0;
      cur_w  <= '0;
      cur_h  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt <= (element_count > MAX_CNT) ? MAX_CNT : element_count;
        idx <= '0;
      end
      if (state == S_LOAD) begin
        cur_sx <= tbl_sx[ld_idx];
        cur_sy <= tbl_sy[ld_idx];
        cur_fx <= tbl_fx[ld_idx];
        cur_fy <= tbl_fy[ld_idx];
        cur_w  <= tbl_w[ld_idx];
        cur_h  <= tbl_h[ld_idx];
      end
      if (state == S_NEXT) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk_33m) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_BG;
      S_BG: begin
        busy = 1'b1;
        if (gen_done && advance) state_nx = (cnt == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        state_nx = ld_skip ? S_NEXT : S_SPRITE;
      end
      S_SPRITE: begin
        busy = 1'b1;
        if (gen_done && advance) state_nx = S_NEXT;
      end
      S_NEXT: begin
        busy     = 1'b1;
        state_nx = (idx + 1'b1 == cnt) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scene_painter.sv
module tb_scene_painter;
  localparam int CW = 12;
  localparam int W  = 40;
  localparam int H  = 20;
  localparam int NBG = W * H;
  localparam logic [1:0] BGP = 2'd1;
`ifdef TRANSPARENT_EN
  localparam bit TRANS = 1'b1;
`else
  localparam bit TRANS = 1'b0;
`endif

  logic clk_33m = 1'b0;
  logic rst = 1'b1, start = 1'b0, desc_we = 1'b0, desc_en = 1'b0, write_ready = 1'b1;
  logic [5:0] element_count = '0;
  logic [4:0] desc_addr = '0;
  logic [CW-1:0] desc_sprite_x = '0, desc_sprite_y = '0, desc_frame_x = '0, desc_frame_y = '0;
  logic [CW-1:0] desc_width = '0, desc_height = '0;
  logic busy, done, sprite_rd, write_valid;
  logic [CW-1:0] sprite_addr_x, sprite_addr_y, write_x, write_y;
  logic [1:0] sprite_palette, write_palette;

  scene_painter #(.COOR_WIDTH(CW), .MAX_ELEMENTS(32), .INDEX_WIDTH(5),
                  .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .BG_PALETTE(BGP)) dut (
    .clk_33m(clk_33m), .rst(rst), .start(start), .element_count(element_count),
    .busy(busy), .done(done), .desc_we(desc_we), .desc_addr(desc_addr), .desc_en(desc_en),
    .desc_sprite_x(desc_sprite_x), .desc_sprite_y(desc_sprite_y),
    .desc_frame_x(desc_frame_x), .desc_frame_y(desc_frame_y),
    .desc_width(desc_width), .desc_height(desc_height),
    .sprite_rd(sprite_rd), .sprite_addr_x(sprite_addr_x), .sprite_addr_y(sprite_addr_y),
    .sprite_palette(sprite_palette), .write_valid(write_valid), .write_ready(write_ready),
    .write_x(write_x), .write_y(write_y), .write_palette(write_palette));

  always #5 clk_33m = ~clk_33m;

  int errors = 0, checks = 0;
  int rom_mode = 0;
  logic [1:0] rom_q = 2'd0;
  logic [25:0] got[$], exp_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, first_acc_cyc = 0, last_acc_cyc = 0;
  int stall_viol = 0, stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [25:0] prev_beat = '0;
  int m_en[32], m_sx[32], m_sy[32], m_fx[32], m_fy[32], m_w[32], m_h[32];

  function automatic logic [1:0] rom_fn(input logic [CW-1:0] ax);
    if (rom_mode == 1 && !ax[0]) return 2'd0;
    return ax[1:0];
  endfunction

  assign sprite_palette = rom_q;
  always @(posedge clk_33m) if (sprite_rd) rom_q <= rom_fn(sprite_addr_x);

  always @(negedge clk_33m) begin
    cyc++;
    if (prev_stall) begin
      stall_cnt++;
      if ({write_valid, write_x, write_y, write_palette} !== {1'b1, prev_beat}) stall_viol++;
    end
    prev_stall = write_valid && !write_ready;
    prev_beat  = {write_x, write_y, write_palette};
    if (write_valid && write_ready) begin
      if (got.size() == 0) first_acc_cyc = cyc;
      got.push_back({write_x, write_y, write_palette});
      last_acc_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic write_desc(input int i, input bit en, input int sx, input int sy,
                            input int fx, input int fy, input int w, input int h);
    @(posedge clk_33m); #1;
    desc_we = 1'b1; desc_addr = 5'(i); desc_en = en;
    desc_sprite_x = CW'(sx); desc_sprite_y = CW'(sy);
    desc_frame_x = CW'(fx); desc_frame_y = CW'(fy);
    desc_width = CW'(w); desc_height = CW'(h);
    @(posedge clk_33m); #1;
    desc_we = 1'b0;
    m_en[i] = en; m_sx[i] = sx; m_sy[i] = sy; m_fx[i] = fx; m_fy[i] = fy; m_w[i] = w; m_h[i] = h;
  endtask

  task automatic build_exp(input int count);
    int n, px, py;
    logic [1:0] pal;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) exp_q.push_back({CW'(x), CW'(y), BGP});
    n = (count > 32) ? 32 : count;
    for (int e = 0; e < n; e++) begin
      if (m_en[e] != 0 && m_w[e] > 0 && m_h[e] > 0)
        for (int r = 0; r < m_h[e]; r++)
          for (int c = 0; c < m_w[e]; c++) begin
            px = m_fx[e] + c; py = m_fy[e] + r;
            pal = rom_fn(CW'(m_sx[e] + c));
            if (px < W && py < H && !(TRANS && pal == 2'd0))
              exp_q.push_back({CW'(px), CW'(py), pal});
          end
    end
  endtask

  // index of first disagreement, -1 when equal; prefix mode accepts a short got
  function automatic int first_diff(input bit prefix);
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (!prefix && got.size() != exp_q.size()) return n;
    if (got.size() > exp_q.size()) return n;
    return -1;
  endfunction

  task automatic start_frame(input int count);
    got.delete();
    element_count = 6'(count);
    @(posedge clk_33m); #1 start = 1'b1;
    @(posedge clk_33m); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_33m); #1;
      if (rnd) write_ready = ($urandom_range(0, 9) >= 3);
      if (done) begin ok = 1'b1; break; end
    end
    write_ready = 1'b1;
    repeat (3) @(posedge clk_33m);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_en[i] = 0;
    repeat (3) @(posedge clk_33m);
    #1 rst = 1'b0;
    @(posedge clk_33m); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (write_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", write_valid); end
    checks++; if (sprite_rd !== 1'b0) begin errors++; $display("FAIL reset_sprite_rd got=%b want=0", sprite_rd); end
    checks++;
    if ({write_x, write_y, write_palette} !== 26'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {write_x, write_y, write_palette});
    end
  endtask

  task automatic test_bg;
    bit ok; int d0, fd;
    d0 = done_cnt;
    build_exp(0);
    start_frame(0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bg_busy_after_start got=%b want=1", busy); end
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bg_timeout done not seen"); end
    checks++; if (got.size() != NBG) begin errors++; $display("FAIL bg_count got=%0d want=%0d", got.size(), NBG); end
    fd = first_diff(1'b0);
    checks++; if (fd != -1) begin errors++; $display("FAIL bg_order first bad beat=%0d", fd); end
    checks++;
    if (done_cyc != last_acc_cyc + 1) begin
      errors++; $display("FAIL bg_done_timing done_cyc=%0d want=%0d", done_cyc, last_acc_cyc + 1);
    end
    checks++;
    if (last_acc_cyc - first_acc_cyc != NBG - 1) begin
      errors++; $display("FAIL bg_throughput span=%0d want=%0d", last_acc_cyc - first_acc_cyc, NBG - 1);
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bg_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bg_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_sprite;
    bit ok; int fd;
    write_desc(0, 1'b1, 4, 2, 10, 6, 8, 5);
    build_exp(1);
    start_frame(1);
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sprite_timeout done not seen"); end
    checks++; if (got.size() != 840) begin errors++; $display("FAIL sprite_count got=%0d want=840", got.size()); end
    fd = first_diff(1'b0);
    checks++; if (fd != -1) begin errors++; $display("FAIL sprite_seq first bad beat=%0d", fd); end
    if (got.size() == 840) begin
      checks++;
      if (got[800] !== {12'd10, 12'd6, 2'd0}) begin errors++; $display("FAIL sprite_first got=%h want=%h", got[800], {12'd10, 12'd6, 2'd0}); end
      checks++;
      if (got[839] !== {12'd17, 12'd10, 2'd3}) begin errors++; $display("FAIL sprite_last got=%h want=%h", got[839], {12'd17, 12'd10, 2'd3}); end
    end
  endtask

  task automatic test_clip;
    bit ok; int fd, d0;
    d0 = done_cnt;
    write_desc(0, 1'b1, 0, 0, 36, 16, 9, 7);
    build_exp(1);
    start_frame(1);
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clip_timeout done not seen"); end
    checks++; if (got.size() != NBG + 16) begin errors++; $display("FAIL clip_count got=%0d want=%0d", got.size(), NBG + 16); end
    fd = first_diff(1'b0);
    checks++; if (fd != -1) begin errors++; $display("FAIL clip_seq first bad beat=%0d", fd); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL clip_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_stall;
    bit ok; int fd, sv0, sc0;
    write_desc(0, 1'b1, 4, 2, 10, 6, 8, 5);
    build_exp(1);
    sv0 = stall_viol; sc0 = stall_cnt;
    start_frame(1);
    wait_done(8000, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout done not seen"); end
    fd = first_diff(1'b0);
    checks++; if (fd != -1) begin errors++; $display("FAIL stall_seq first bad beat=%0d size=%0d", fd, got.size()); end
    checks++; if (stall_viol != sv0) begin errors++; $display("FAIL stall_stable violations=%0d want=0", stall_viol - sv0); end
    checks++; if (stall_cnt == sc0) begin errors++; $display("FAIL stall_seen stalls=0 want>0"); end
  endtask

  task automatic test_back_to_back;
    bit ok; int d0;
    build_exp(1);
    d0 = done_cnt;
    start_frame(1);
    repeat (50) @(posedge clk_33m);
    #1 start = 1'b1;
    @(posedge clk_33m); #1 start = 1'b0;
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok || got.size() != 840) begin errors++; $display("FAIL b2b_ignored_start got=%0d want=840", got.size()); end
    start_frame(1);
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok || first_diff(1'b0) != -1) begin errors++; $display("FAIL b2b_second_frame got=%0d want=840", got.size()); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done got=%0d want=2", done_cnt - d0); end
  endtask

  task automatic test_skip_abort;
    bit reached; int n, d0, fd;
    write_desc(0, 1'b1, 0, 0, 2, 1, 3, 2);
    write_desc(1, 1'b0, 0, 0, 5, 5, 4, 4);
    write_desc(2, 1'b1, 0, 0, 5, 5, 0, 4);
    write_desc(3, 1'b1, 1, 1, 20, 10, 6, 4);
    build_exp(4);
    checks++; if (exp_q.size() != NBG + 30) begin errors++; $display("FAIL skip_model size=%0d want=%0d", exp_q.size(), NBG + 30); end
    start_frame(4);
    reached = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk_33m); #1;
      if (got.size() >= NBG + 11) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL skip_reach_elem3 got=%0d beats", got.size()); end
    fd = first_diff(1'b1);
    checks++; if (fd != -1) begin errors++; $display("FAIL skip_prefix first bad beat=%0d", fd); end
    d0 = done_cnt;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_en[i] = 0;
    @(posedge clk_33m); #1;
    n = got.size();
    checks++; if (write_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", write_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    repeat (2) @(posedge clk_33m);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk_33m);
    #1;
    checks++; if (got.size() != n) begin errors++; $display("FAIL abort_beats got=%0d want=%0d", got.size(), n); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_saturate;
    bit ok; int fd;
    write_desc(0, 1'b1, 4, 2, 10, 6, 8, 5);
    build_exp(63);
    start_frame(63);
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_timeout done not seen"); end
    fd = first_diff(1'b0);
    checks++; if (fd != -1) begin errors++; $display("FAIL sat_seq first bad beat=%0d size=%0d want=%0d", fd, got.size(), exp_q.size()); end
  endtask

  task automatic test_transparent;
    bit ok; int fd;
    rom_mode = 1;
    write_desc(0, 1'b1, 4, 2, 10, 6, 8, 5);
    build_exp(1);
    start_frame(1);
    wait_done(5000, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL trans_timeout done not seen"); end
    checks++; if (got.size() != NBG + 20) begin errors++; $display("FAIL trans_count got=%0d want=%0d", got.size(), NBG + 20); end
    fd = first_diff(1'b0);
    checks++; if (fd != -1) begin errors++; $display("FAIL trans_seq first bad beat=%0d", fd); end
    rom_mode = 0;
  endtask

  initial begin
    test_reset();
    test_bg();
    test_sprite();
    test_clip();
    test_stall();
    test_back_to_back();
    test_skip_abort();
    test_saturate();
    if (TRANS) test_transparent();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
